// File: rtl/msg_schedule_gen.sv
// SHA-2 message schedule generator: expands a 16-word block into
// ROUNDS schedule words over a 16-entry sliding window.
module msg_schedule_gen #(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64,
  parameter int TW     = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  input  logic [16*WIDTH-1:0]   blk_i,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic [WIDTH-1:0]      w_o,
  output logic [TW-1:0]         t_o,
  output logic                  last_o,
  output logic                  busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam bit WIDE = (WIDTH == 64);

  // Rotation / shift amounts for the small sigma functions
  localparam int S0_R1 = WIDE ? 1  : 7;
  localparam int S0_R2 = WIDE ? 8  : 18;
  localparam int S0_SH = WIDE ? 7  : 3;
  localparam int S1_R1 = WIDE ? 19 : 17;
  localparam int S1_R2 = WIDE ? 61 : 19;
  localparam int S1_SH = WIDE ? 6  : 10;

  localparam logic [TW-1:0] T_LAST = TW'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] win_q [16];
  logic [WIDTH-1:0] win_d [16];
  logic [TW-1:0]    t_q, t_d;
  logic [WIDTH-1:0] w_new;
  logic             hs;
  logic             at_last;

  function automatic logic [WIDTH-1:0] rotr(
    input logic [WIDTH-1:0] x,
    input int               n
  );
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] sig0(
    input logic [WIDTH-1:0] x
  );
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [WIDTH-1:0] sig1(
    input logic [WIDTH-1:0] x
  );
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

  // Modulo-2^WIDTH sum; the adder width drops the carries
  assign w_new = sig1(win_q[14]) + win_q[9]
               + sig0(win_q[1]) + win_q[0];

  assign hs      = (state_q == RUN) && w_ready_i;
  assign at_last = (t_q == T_LAST);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end
    unique case (state_q)
      IDLE: begin
        if (blk_valid_i) begin
          state_d = RUN;
          t_d     = '0;
          for (int i = 0; i < 16; i++) begin
            win_d[i] = blk_i[(15-i)*WIDTH +: WIDTH];
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (at_last) begin
            state_d = IDLE;
          end else begin
            t_d = t_q + TW'(1);
            for (int i = 0; i < 15; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[15] = w_new;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign blk_ready_o = (state_q == IDLE);
  assign w_valid_o   = (state_q == RUN);
  assign busy_o      = (state_q == RUN);
  assign w_o         = win_q[0];
  assign t_o         = t_q;
  assign last_o      = (state_q == RUN) && at_last;

endmodule

// File: tb/tb_msg_schedule_gen.sv
// Randomized bench for msg_schedule_gen, SHA-256 and SHA-512 instances
// checked against a recurrence-based schedule model.
module tb_msg_schedule_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic bv;
  logic rdy_in;
  logic sel;

  logic [16*32-1:0] blk32;
  logic [16*64-1:0] blk64;

  logic        br32, wv32, la32, bz32;
  logic [31:0] w32;
  logic [6:0]  t32;
  logic        br64, wv64, la64, bz64;
  logic [63:0] w64;
  logic [6:0]  t64;

  msg_schedule_gen #(.WIDTH(32), .ROUNDS(64), .TW(7)) u_dut32 (
    .clk_i       (clk),
    .rst_i       (rst),
    .blk_valid_i (bv & ~sel),
    .blk_ready_o (br32),
    .blk_i       (blk32),
    .w_valid_o   (wv32),
    .w_ready_i   (rdy_in & ~sel),
    .w_o         (w32),
    .t_o         (t32),
    .last_o      (la32),
    .busy_o      (bz32)
  );

  msg_schedule_gen #(.WIDTH(64), .ROUNDS(80), .TW(7)) u_dut64 (
    .clk_i       (clk),
    .rst_i       (rst),
    .blk_valid_i (bv & sel),
    .blk_ready_o (br64),
    .blk_i       (blk64),
    .w_valid_o   (wv64),
    .w_ready_i   (rdy_in & sel),
    .w_o         (w64),
    .t_o         (t64),
    .last_o      (la64),
    .busy_o      (bz64)
  );

  wire        o_rdy  = sel ? br64 : br32;
  wire        o_vld  = sel ? wv64 : wv32;
  wire        o_last = sel ? la64 : la32;
  wire        o_busy = sel ? bz64 : bz32;
  wire [63:0] o_w    = sel ? w64 : {32'b0, w32};
  wire [6:0]  o_t    = sel ? t64 : t32;

  int tests = 0;
  int fails = 0;

  logic [63:0] m [16];
  logic [63:0] mb [16];
  logic [63:0] exp_w [80];
  logic [63:0] got_w [80];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x,
                                       input int n, input bit wide);
    logic [31:0] v;
    if (wide) return (x >> n) | (x << (64 - n));
    v = x[31:0];
    v = (v >> n) | (v << (32 - n));
    return {32'b0, v};
  endfunction

  function automatic logic [63:0] ss0(input logic [63:0] x, input bit wide);
    if (wide) return rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7);
    return rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ {32'b0, x[31:0] >> 3};
  endfunction

  function automatic logic [63:0] ss1(input logic [63:0] x, input bit wide);
    if (wide) return rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6);
    return rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ {32'b0, x[31:0] >> 10};
  endfunction

  // Textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  task automatic model(input bit wide);
    logic [63:0] mask;
    int rounds;
    mask   = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    rounds = wide ? 80 : 64;
    for (int i = 0; i < 16; i++) exp_w[i] = m[i] & mask;
    for (int t = 16; t < rounds; t++)
      exp_w[t] = (ss1(exp_w[t-2], wide) + exp_w[t-7]
                + ss0(exp_w[t-15], wide) + exp_w[t-16]) & mask;
  endtask

  task automatic pack(input bit wide);
    for (int i = 0; i < 16; i++) begin
      blk32[(15-i)*32 +: 32] = m[i][31:0];
      blk64[(15-i)*64 +: 64] = m[i];
    end
  endtask

  task automatic set_abc(input bit wide);
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = wide ? 64'h6162638000000000 : 64'h61626380;
    m[15] = 64'h18;
  endtask

  task automatic set_rand(input bit wide);
    for (int i = 0; i < 16; i++)
      m[i] = wide ? {$urandom, $urandom} : {32'b0, $urandom};
  endtask

  task automatic run_block(input bit wide, input bit rnd, input int rst_at);
    int e, cyc, rounds;
    rounds = wide ? 80 : 64;
    model(wide);
    @(negedge clk);
    sel = wide;
    rdy_in = 1'b0;
    #1;
    chk("idle_rdy", o_rdy, 1);
    pack(wide);
    bv = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    blk32 = {16{$urandom}};
    blk64 = {32{$urandom}};
    e = 0;
    cyc = 0;
    while (e < rounds && cyc < 2000) begin
      cyc++;
      if (rst_at == e) begin
        rst = 1'b1;
        rdy_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdy_in = 1'b0;
        chk("rst_vld", o_vld, 0);
        chk("rst_rdy", o_rdy, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_t", o_t, 0);
        chk("rst_w", o_w, 0);
        return;
      end
      chk("vld", o_vld, 1);
      chk("w", o_w, exp_w[e]);
      chk("t", o_t, e);
      chk("last", o_last, (e == rounds - 1));
      chk("blk_rdy_run", o_rdy, 0);
      got_w[e] = o_w;
      rdy_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rdy_in) e++;
    end
    rdy_in = 1'b0;
    chk("timeout", (cyc < 2000), 1);
    if (!rnd) chk("thruput", cyc, rounds);
    chk("done_vld", o_vld, 0);
    chk("done_busy", o_busy, 0);
    chk("done_rdy", o_rdy, 1);
  endtask

  task automatic gap_test();
    int cyc, a1, a2, drain;
    bit swapped;
    sel = 1'b0;
    set_abc(0);
    for (int i = 0; i < 16; i++) mb[i] = {32'b0, $urandom};
    pack(0);
    @(negedge clk);
    bv = 1'b1;
    rdy_in = 1'b1;
    a1 = -1;
    a2 = -1;
    cyc = 0;
    swapped = 0;
    while (a2 < 0 && cyc < 300) begin
      if (a1 >= 0 && !swapped) begin
        for (int i = 0; i < 16; i++) m[i] = mb[i];
        pack(0);
        swapped = 1;
      end
      if (o_rdy && bv) begin
        if (a1 < 0) a1 = cyc;
        else a2 = cyc;
      end
      if (a2 < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    bv = 1'b0;
    chk("gap", a2 - a1, 65);
    chk("gap_w0", o_w, mb[0]);
    chk("gap_t0", o_t, 0);
    drain = 0;
    while (o_vld && drain < 200) begin
      @(negedge clk);
      drain++;
    end
    rdy_in = 1'b0;
    chk("gap_drain", drain, 64);
  endtask

  initial begin
    rst = 1'b1;
    bv = 1'b0;
    rdy_in = 1'b0;
    sel = 1'b0;
    blk32 = '0;
    blk64 = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld32", wv32, 0);
    chk("rst_last32", la32, 0);
    chk("rst_busy32", bz32, 0);
    chk("rst_t32", t32, 0);
    chk("rst_w32", w32, 0);
    chk("rst_rdy32", br32, 1);
    chk("rst_vld64", wv64, 0);
    chk("rst_w64", w64, 0);
    chk("rst_rdy64", br64, 1);
    rst = 1'b0;

    set_abc(0);
    run_block(0, 0, -1);
    chk("abc_w0", got_w[0], 64'h61626380);
    chk("abc_w16", got_w[16], 64'h61626380);
    chk("abc_w17", got_w[17], 64'h000F0000);

    set_abc(0);
    run_block(0, 1, -1);

    rdy_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_vld", o_vld, 0);
    end
    rdy_in = 1'b0;

    rst = 1'b1;
    bv = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bv = 1'b0;
    chk("rstpri_vld", o_vld, 0);
    chk("rstpri_rdy", o_rdy, 1);

    set_abc(0);
    run_block(0, 0, 30);
    set_abc(0);
    run_block(0, 0, -1);

    gap_test();

    for (int i = 0; i < 16; i++) m[i] = 64'hFFFF_FFFF;
    run_block(0, 1, -1);
    chk("ones_w16", got_w[16], exp_w[16]);

    repeat (4) begin
      set_rand(0);
      run_block(0, 1, -1);
    end

    set_abc(1);
    run_block(1, 0, -1);
    chk("abc512_w16", got_w[16], 64'h6162638000000000);
    set_rand(1);
    run_block(1, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
